// File: rtl/i2c_pkg.sv
// Shared command and state encodings for the I2C bit-level line driver.
package i2c_pkg;

    typedef enum logic [1:0] {
        I2C_CMD_START = 2'b00,
        I2C_CMD_STOP  = 2'b01,
        I2C_CMD_WRITE = 2'b10,
        I2C_CMD_READ  = 2'b11
    } i2c_cmd_e;

    // Upper two bits select the command family, lower two bits the phase A..D.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'h0,
        ST_START_A = 4'h4,
        ST_START_B = 4'h5,
        ST_START_C = 4'h6,
        ST_START_D = 4'h7,
        ST_STOP_A  = 4'h8,
        ST_STOP_B  = 4'h9,
        ST_STOP_C  = 4'hA,
        ST_STOP_D  = 4'hB,
        ST_BIT_A   = 4'hC,
        ST_BIT_B   = 4'hD,
        ST_BIT_C   = 4'hE,
        ST_BIT_D   = 4'hF
    } i2c_state_e;

    function automatic i2c_state_e i2c_first_state(input i2c_cmd_e c);
        i2c_state_e s;
        case (c)
            I2C_CMD_START: s = ST_START_A;
            I2C_CMD_STOP:  s = ST_STOP_A;
            default:       s = ST_BIT_A;
        endcase
        return s;
    endfunction

    function automatic logic i2c_is_phase_b(input i2c_state_e s);
        return (s == ST_START_B) || (s == ST_STOP_B) || (s == ST_BIT_B);
    endfunction

    function automatic logic i2c_is_phase_d(input i2c_state_e s);
        return (s == ST_START_D) || (s == ST_STOP_D) || (s == ST_BIT_D);
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-SCL-period counter: counts 0..Q-1, clearable, freezable for clock stretching.
module i2c_quarter_timer #(
    parameter int unsigned QUARTER_PERIOD = 125
) (
    input  logic fastClock,
    input  logic resetN,
    input  logic clear,
    input  logic hold,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned CW = (QUARTER_PERIOD > 2) ? $clog2(QUARTER_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER_PERIOD - 1);
    localparam logic [CW-1:0] PRE  = CW'(QUARTER_PERIOD - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!hold) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge fastClock or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick      = (count_q == LAST);
    // High one cycle ahead of tick so phase-end outputs can be registered.
    assign tick_next = !clear && !hold && (count_q == PRE);

endmodule

// File: rtl/i2c_bit_driver.sv
// Bit-level I2C master: turns START/STOP/WRITE/READ commands into registered
// open-drain SCL/SDA enables, with clock stretching, read sampling and arbitration.
module i2c_bit_driver
    import i2c_pkg::*;
#(
    parameter int unsigned QUARTER_PERIOD = 125
) (
    input  logic       fastClock,
    input  logic       resetN,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmd,
    input  logic       txBit,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sclOe,
    output logic       sdaOe,
    output logic       done,
    output logic       rxBit,
    output logic       arbLost
);

    i2c_state_e state_q, state_d;
    i2c_cmd_e   cmd_q, cmd_d;
    logic       tx_q, tx_d;
    logic       rx_q, rx_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       done_q, done_d;
    logic       arb_q, arb_d;
    logic       ready_q, ready_d;

    logic       tick;
    logic       tick_next;
    logic       clear;
    logic       hold;
    logic       advance;

    assign clear   = (state_q == ST_IDLE);
    // Slave holding SCL low at the end of phase B freezes the phase.
    assign hold    = i2c_is_phase_b(state_q) && tick && !sclIn;
    assign advance = tick && !hold;

    i2c_quarter_timer #(
        .QUARTER_PERIOD(QUARTER_PERIOD)
    ) u_timer (
        .fastClock(fastClock),
        .resetN   (resetN),
        .clear    (clear),
        .hold     (hold),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        done_d   = 1'b0;
        arb_d    = 1'b0;

        // The done cycle is always the last cycle of a command, normal or aborted.
        if (done_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmdValid) begin
                        cmd_d   = i2c_cmd_e'(cmd);
                        tx_d    = txBit;
                        state_d = i2c_first_state(i2c_cmd_e'(cmd));
                    end
                end
                ST_START_A: if (advance) state_d = ST_START_B;
                ST_START_B: if (advance) state_d = ST_START_C;
                ST_START_C: if (advance) state_d = ST_START_D;
                ST_STOP_A:  if (advance) state_d = ST_STOP_B;
                ST_STOP_B:  if (advance) state_d = ST_STOP_C;
                ST_STOP_C:  if (advance) state_d = ST_STOP_D;
                ST_BIT_A:   if (advance) state_d = ST_BIT_B;
                ST_BIT_B: begin
                    if (advance) begin
                        state_d = ST_BIT_C;
                        rx_d    = sdaIn;
                        arb_d   = (cmd_q == I2C_CMD_WRITE) && tx_q && !sdaIn;
                    end
                end
                ST_BIT_C:   if (advance) state_d = ST_BIT_D;
                default:    state_d = state_q;
            endcase
            if (i2c_is_phase_d(state_q) && tick_next) begin
                done_d = 1'b1;
            end
        end

        // Line enables follow the phase being entered; IDLE keeps the last values.
        case (state_d)
            ST_START_A: sda_oe_d = 1'b0;
            ST_START_B: scl_oe_d = 1'b0;
            ST_START_C: sda_oe_d = 1'b1;
            ST_START_D: scl_oe_d = 1'b1;
            ST_STOP_A: begin
                scl_oe_d = 1'b1;
                sda_oe_d = 1'b1;
            end
            ST_STOP_B:  scl_oe_d = 1'b0;
            ST_STOP_C:  sda_oe_d = 1'b0;
            ST_STOP_D: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
            ST_BIT_A: begin
                scl_oe_d = 1'b1;
                sda_oe_d = (cmd_d == I2C_CMD_WRITE) ? !tx_d : 1'b0;
            end
            ST_BIT_B, ST_BIT_C: scl_oe_d = 1'b0;
            ST_BIT_D:   scl_oe_d = 1'b1;
            default: begin
            end
        endcase

        if (arb_d) begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            done_d   = 1'b1;
        end
    end

    assign ready_d = (state_d == ST_IDLE);

    always_ff @(posedge fastClock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            cmd_q    <= I2C_CMD_START;
            tx_q     <= 1'b0;
            rx_q     <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
            arb_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= done_d;
            arb_q    <= arb_d;
            ready_q  <= ready_d;
        end
    end

    assign cmdReady = ready_q;
    assign sclOe    = scl_oe_q;
    assign sdaOe    = sda_oe_q;
    assign done     = done_q;
    assign rxBit    = rx_q;
    assign arbLost  = arb_q;

endmodule
